// File: rtl/qmem_sram16.sv
// qmem_sram16 -- QMEM 16-bit slave driving an external asynchronous 16-bit SRAM.
//
// Turns single-word QMEM accesses into timed SRAM cycles. Every output is a
// register decoded from the FSM state of the previous cycle. So the SRAM sees
// the address for one cycle before any strobe goes low, and ack follows the
// last strobe cycle by one cycle.
//
// Handshake: the master raises cs with adr/we/sel/dat_w and holds cs high
// until ack. The request is taken at the first edge where the FSM is IDLE and
// cs=1. Request inputs are not sampled again until the access completes. ack
// is a one-cycle pulse, and dat_r is valid in that cycle for reads.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   adr, cs, we, sel  QMEM request (byte address, select, direction, byte enables)
//   dat_w / dat_r     QMEM write / read data
//   ack, err          access-complete pulse; error (always 0)
//   sram_*            SRAM address, data, tristate enable, active-low strobes
//   state_dbg         current FSM state (encoding of state_t)
module qmem_sram16 #(
    parameter int QAW   = 22,
    parameter int QSW   = 2,
    parameter int QDW   = 16,
    parameter int SAW   = 18,
    parameter int RD_WS = 2,
    parameter int WR_WS = 2,
    parameter int TURN  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [QAW-1:0] adr,
    input  logic           cs,
    input  logic           we,
    input  logic [QSW-1:0] sel,
    input  logic [QDW-1:0] dat_w,
    output logic [QDW-1:0] dat_r,
    output logic           ack,
    output logic           err,
    output logic [SAW-1:0] sram_adr,
    output logic [15:0]    sram_dat_w,
    input  logic [15:0]    sram_dat_r,
    output logic           sram_dat_oe,
    output logic           sram_ce_n,
    output logic           sram_oe_n,
    output logic           sram_we_n,
    output logic           sram_ub_n,
    output logic           sram_lb_n,
    output logic [2:0]     state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_ACK      = 3'd5,
        S_TURN     = 3'd6
    } state_t;

    // The wait counter holds "cycles left in this state minus one".
    localparam logic [3:0] RD_CNT   = 4'(RD_WS);
    localparam logic [3:0] WR_CNT   = 4'(WR_WS - 1);
    localparam logic [3:0] TURN_CNT = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q;
    logic [1:0] sel_q;
    logic       accept;
    logic       wr_phase;

    // Only adr[SAW:1] selects a SRAM word. adr[0] and the upper bits are dropped.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{adr[QAW-1:SAW+1], adr[0]};

    assign err       = 1'b0;
    assign state_dbg = state_q;
    assign accept    = (state_q == S_IDLE) && cs;
    assign wr_phase  = (state_q == S_WR_SETUP) || (state_q == S_WR_PULSE) ||
                       (state_q == S_WR_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cs) begin
                    if (we) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = RD_CNT;
                    end
                end
            end
            S_RD: begin
                if (cnt_q == 4'd0) state_d = S_ACK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = WR_CNT;
            end
            S_WR_PULSE: begin
                if (cnt_q == 4'd0) state_d = S_WR_HOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_WR_HOLD: state_d = S_ACK;
            S_ACK: begin
                if (TURN > 0) begin
                    state_d = S_TURN;
                    cnt_d   = TURN_CNT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request is captured once at accept and held for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            sel_q      <= 2'b00;
            sram_adr   <= '0;
            sram_dat_w <= 16'h0000;
        end else if (accept) begin
            we_q       <= we;
            sel_q      <= sel;
            sram_adr   <= adr[SAW:1];
            sram_dat_w <= dat_w;
        end
    end

    // Strobes are the registered decode of the current state. dat_oe comes
    // only from write states and oe_n only from RD. They cannot overlap, and
    // the ACK state always puts an all-inactive cycle between two accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack         <= 1'b0;
            dat_r       <= '0;
            sram_dat_oe <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            ack         <= (state_q == S_ACK);
            sram_dat_oe <= wr_phase;
            sram_ce_n   <= !((state_q == S_RD) || wr_phase);
            sram_oe_n   <= (state_q != S_RD);
            // A write with no byte enables runs its full timing without a pulse.
            sram_we_n   <= !((state_q == S_WR_PULSE) && (sel_q != 2'b00));
            sram_ub_n   <= !((state_q == S_RD) || (wr_phase && sel_q[1]));
            sram_lb_n   <= !((state_q == S_RD) || (wr_phase && sel_q[0]));
            // In the ACK state the read strobes are still low from the last
            // RD cycle, so the SRAM has driven its data for RD_WS+1 cycles.
            if ((state_q == S_ACK) && !we_q) dat_r <= sram_dat_r;
        end
    end

endmodule

// File: tb/tb_qmem_sram16.sv
// Directed bench for qmem_sram16 with RD_WS=2, WR_WS=2, TURN=1 and a
// behavioural asynchronous SRAM model.
module tb_qmem_sram16;

    localparam int BUDGET = 40;

    logic        clk;
    logic        rst;
    logic [21:0] adr;
    logic        cs;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] dat_w;
    logic [15:0] dat_r;
    logic        ack;
    logic        err;
    logic [17:0] sram_adr;
    logic [15:0] sram_dat_w;
    logic [15:0] sram_dat_r;
    logic        sram_dat_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic [2:0]  state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    qmem_sram16 #(.QAW(22), .QSW(2), .QDW(16), .SAW(18),
                  .RD_WS(2), .WR_WS(2), .TURN(1)) dut (
        .clk(clk), .rst(rst), .adr(adr), .cs(cs), .we(we), .sel(sel),
        .dat_w(dat_w), .dat_r(dat_r), .ack(ack), .err(err),
        .sram_adr(sram_adr), .sram_dat_w(sram_dat_w), .sram_dat_r(sram_dat_r),
        .sram_dat_oe(sram_dat_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .state_dbg(state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: reads are combinational, and writes happen at every edge
    // where the write strobe is low. The bench preloads words through pl_*.
    logic [15:0] mem [0:262143];
    logic        pl_en = 1'b0;
    logic [17:0] pl_a  = '0;
    logic [15:0] pl_d  = '0;

    assign sram_dat_r = (!sram_ce_n && !sram_oe_n) ? mem[sram_adr] : 16'hDEAD;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_adr][15:8] <= sram_dat_w[15:8];
            if (!sram_lb_n) mem[sram_adr][7:0]  <= sram_dat_w[7:0];
        end
    end

    // Bus monitor: running counts sampled at the falling edge.
    int ce_lo = 0, oe_lo = 0, we_lo = 0, overlap = 0, ack_seen = 0;
    always @(negedge clk) begin
        if (!sram_ce_n) ce_lo++;
        if (!sram_oe_n) oe_lo++;
        if (!sram_we_n) we_lo++;
        if (sram_dat_oe && !sram_oe_n) overlap++;
        if (ack) ack_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Values captured in cycle 2 of the most recent access.
    logic [17:0] snap_adr;
    logic        snap_ub, snap_lb;

    // One access: drive the request while the FSM is idle, then count cycles
    // after the accept edge until ack. lat = -1 means the budget ran out.
    task automatic run_access(input logic [21:0] a, input logic w, input logic [1:0] s,
                              input logic [15:0] d, output int lat,
                              output int ce_n_cnt, output int oe_n_cnt, output int we_n_cnt);
        int ce0, oe0, we0;
        repeat (2) @(negedge clk);
        adr = a; we = w; sel = s; dat_w = d; cs = 1'b1;
        @(posedge clk);
        ce0 = ce_lo; oe0 = oe_lo; we0 = we_lo;
        lat = -1;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk); #1;
            if (n == 2) begin
                snap_adr = sram_adr; snap_ub = sram_ub_n; snap_lb = sram_lb_n;
            end
            if (ack) begin
                lat = n;
                break;
            end
        end
        cs = 1'b0;
        ce_n_cnt = ce_lo - ce0; oe_n_cnt = oe_lo - oe0; we_n_cnt = we_lo - we0;
    endtask

    int lat, nce, noe, nwe, ov0, ack0, lat2;

    initial begin
        rst = 1'b1; cs = 1'b0; we = 1'b0; sel = 2'b00; adr = '0; dat_w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat_r", 32'(dat_r), 32'd0);
        check("rst_sram_adr", 32'(sram_adr), 32'd0);
        check("rst_sram_dat_w", 32'(sram_dat_w), 32'd0);
        check("rst_dat_oe", 32'(sram_dat_oe), 32'd0);
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_ub_lb_n", 32'({sram_ub_n, sram_lb_n}), 32'd3);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;

        // 1: read word 0x92 (byte address 0x124)
        preload(18'h00092, 16'hBEEF);
        run_access(22'h000124, 1'b0, 2'b11, 16'h0000, lat, nce, noe, nwe);
        check("rd_sram_adr", 32'(snap_adr), 32'h00092);
        check("rd_latency", 32'(lat), 32'd4);
        check("rd_ce_low_cycles", 32'(nce), 32'd3);
        check("rd_oe_low_cycles", 32'(noe), 32'd3);
        check("rd_dat_r", 32'(dat_r), 32'h0000BEEF);
        check("rd_we_low_cycles", 32'(nwe), 32'd0);

        // 2: upper-byte write to word 8
        preload(18'h00008, 16'h1122);
        run_access(22'h000010, 1'b1, 2'b10, 16'hA55A, lat, nce, noe, nwe);
        check("wr_latency", 32'(lat), 32'd5);
        check("wr_we_low_cycles", 32'(nwe), 32'd2);
        check("wr_ce_low_cycles", 32'(nce), 32'd4);
        check("wr_ub_n", 32'(snap_ub), 32'd0);
        check("wr_lb_n", 32'(snap_lb), 32'd1);
        check("wr_mem8", 32'(mem[8]), 32'h0000A522);
        check("wr_dat_r_held", 32'(dat_r), 32'h0000BEEF);

        // 3: write then read of word 3 with cs held high across the write ack
        preload(18'h00003, 16'h0000);
        repeat (2) @(negedge clk);
        adr = 22'h000006; we = 1'b1; sel = 2'b11; dat_w = 16'h1234; cs = 1'b1;
        @(posedge clk);
        ov0 = overlap;
        lat = -1;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk); #1;
            if (ack) begin lat = n; break; end
        end
        check("b2b_wr_latency", 32'(lat), 32'd5);
        we = 1'b0;
        lat2 = -1;
        for (int n = 1; n < BUDGET; n++) begin
            @(negedge clk); #1;
            if (ack) begin lat2 = n; break; end
        end
        cs = 1'b0;
        check("b2b_rd_after_wr_ack", 32'(lat2), 32'd6);
        check("b2b_dat_r", 32'(dat_r), 32'h00001234);
        check("b2b_mem3", 32'(mem[3]), 32'h00001234);
        check("b2b_bus_overlap", 32'(overlap - ov0), 32'd0);

        // 4: write with no byte enables
        run_access(22'h000010, 1'b1, 2'b00, 16'hFFFF, lat, nce, noe, nwe);
        check("sel0_latency", 32'(lat), 32'd5);
        check("sel0_we_low_cycles", 32'(nwe), 32'd0);
        check("sel0_mem8", 32'(mem[8]), 32'h0000A522);

        // 6: address boundary
        preload(18'h3FFFF, 16'h5A5A);
        run_access(22'h07FFFE, 1'b0, 2'b11, 16'h0000, lat, nce, noe, nwe);
        check("top_sram_adr", 32'(snap_adr), 32'h3FFFF);
        check("top_dat_r", 32'(dat_r), 32'h00005A5A);
        preload(18'h00000, 16'h0F0F);
        run_access(22'h080000, 1'b0, 2'b11, 16'h0000, lat, nce, noe, nwe);
        check("wrap_sram_adr", 32'(snap_adr), 32'h00000);
        check("wrap_dat_r", 32'(dat_r), 32'h00000F0F);
        check("wrap_err", 32'(err), 32'd0);

        // 5: reset during the second write-pulse cycle
        repeat (2) @(negedge clk);
        adr = 22'h00000A; we = 1'b1; sel = 2'b11; dat_w = 16'h7777; cs = 1'b1;
        @(posedge clk);
        ack0 = ack_seen;
        repeat (4) @(negedge clk);
        #1;
        check("abort_we_low_before_rst", 32'(sram_we_n), 32'd0);
        rst = 1'b1; cs = 1'b0;
        @(negedge clk); #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_ce_n", 32'(sram_ce_n), 32'd1);
        check("abort_dat_oe", 32'(sram_dat_oe), 32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_dat_r", 32'(dat_r), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_ack", 32'(ack_seen - ack0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
